// File: rtl/iic_read8_if.sv
// Handshake/strobe bundle between the I2C sequencer (master) and the byte read engine (slave).
// With IIC_READ8_CRC_EN defined the bundle also carries the running CRC-8 signals.
interface iic_read8_if;
  logic       start;
  logic       ack_en;
  logic       abort;
  logic       scl_hs;
  logic       scl_lc;
  logic       busy;
  logic       done;
  logic [7:0] data_out;
`ifdef IIC_READ8_CRC_EN
  logic       crc_clr;
  logic       crc_ok;
  logic [7:0] crc_val;

  modport master (
    output start, ack_en, abort, scl_hs, scl_lc, crc_clr,
    input  busy, done, data_out, crc_ok, crc_val
  );

  modport slave (
    input  start, ack_en, abort, scl_hs, scl_lc, crc_clr,
    output busy, done, data_out, crc_ok, crc_val
  );
`else
  modport master (
    output start, ack_en, abort, scl_hs, scl_lc,
    input  busy, done, data_out
  );

  modport slave (
    input  start, ack_en, abort, scl_hs, scl_lc,
    output busy, done, data_out
  );
`endif
endinterface

// File: rtl/iic_read8.sv
// I2C receive byte engine: samples 8 bits MSB-first on SCL-high strobes, then drives ACK/NACK.
// Optional running SHT21 CRC-8 (poly 0x31) enabled by defining IIC_READ8_CRC_EN.
module iic_read8 #(
  parameter int unsigned SYNC_STAGES = 2  // legal range 2..3
) (
  input  logic       clk,
  input  logic       rst_n,
  iic_read8_if.slave bus,
  inout  wire        sda_io
);

  typedef enum logic [2:0] {
    StIdle,
    StData,
    StAckSetup,
    StAckHold,
    StAckEnd
  } state_e;

  state_e                 state_q, state_d;
  logic [7:0]             shift_q, shift_d;
  logic [2:0]             bitcnt_q, bitcnt_d;
  logic                   ack_en_q, ack_en_d;
  logic                   oe_q, oe_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [7:0]             data_q, data_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sda_sync;
  logic                   hs;
  logic                   lc;

  // Open-drain: only ever pull low.
  assign sda_io   = oe_q ? 1'b0 : 1'bz;
  assign sda_sync = sync_q[SYNC_STAGES-1];

  // A coincident low strobe is dropped in favour of the high strobe.
  assign hs = bus.scl_hs;
  assign lc = bus.scl_lc & ~bus.scl_hs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sda_io};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      shift_q  <= 8'h00;
      bitcnt_q <= 3'd7;
      ack_en_q <= 1'b0;
      oe_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      data_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      ack_en_q <= ack_en_d;
      oe_q     <= oe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      data_q   <= data_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    ack_en_d = ack_en_q;
    oe_d     = oe_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    data_d   = data_q;

    if (bus.abort) begin
      state_d = StIdle;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          oe_d = 1'b0;
          // A start in the done cycle is a protocol error and is dropped.
          if (bus.start && !done_q) begin
            ack_en_d = bus.ack_en;
            bitcnt_d = 3'd7;
            busy_d   = 1'b1;
            state_d  = StData;
          end
        end
        StData: begin
          oe_d = 1'b0;
          if (hs) begin
            shift_d[bitcnt_q] = sda_sync;
            if (bitcnt_q == 3'd0) begin
              state_d = StAckSetup;
            end else begin
              bitcnt_d = bitcnt_q - 3'd1;
            end
          end
        end
        StAckSetup: begin
          if (lc) begin
            oe_d    = ack_en_q;
            state_d = StAckHold;
          end
        end
        StAckHold: begin
          if (hs) begin
            state_d = StAckEnd;
          end
        end
        StAckEnd: begin
          if (lc) begin
            oe_d    = 1'b0;
            data_d  = shift_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
          end
        end
        default: begin
          state_d = StIdle;
          oe_d    = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.data_out = data_q;

`ifdef IIC_READ8_CRC_EN
  logic [7:0] crc_q, crc_d;
  logic       crc_ok_q, crc_ok_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q    <= 8'h00;
      crc_ok_q <= 1'b0;
    end else begin
      crc_q    <= crc_d;
      crc_ok_q <= crc_ok_d;
    end
  end

  always_comb begin
    crc_d    = crc_q;
    crc_ok_d = crc_ok_q;
    if (bus.crc_clr || bus.abort) begin
      crc_d = 8'h00;
    end else if (state_q == StData && hs) begin
      crc_d = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ sda_sync) ? 8'h31 : 8'h00);
    end
    if (done_d) begin
      crc_ok_d = (crc_q == 8'h00);
    end
  end

  assign bus.crc_val = crc_q;
  assign bus.crc_ok  = crc_ok_q;
`endif

endmodule

// File: tb/tb_iic_read8.sv
// Randomized bench for iic_read8: bus-level reference model checked every cycle, plus
// literal expectations for the directed byte reads (and CRC when IIC_READ8_CRC_EN is defined).
module tb_iic_read8;
  localparam int unsigned S = 2;

  logic clk        = 1'b0;
  logic rst_n      = 1'b0;
  logic tb_drv_low = 1'b0;
  wire  sda;

  iic_read8_if bus ();

  assign sda = tb_drv_low ? 1'b0 : 1'bz;
  pullup (sda);

  iic_read8 #(.SYNC_STAGES(S)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .sda_io (sda)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: byte read as "8 high-strobe samples, then low/high/low for the ACK slot".
  logic       m_busy   = 1'b0;
  logic       m_done   = 1'b0;
  logic       m_oe     = 1'b0;
  logic       m_ack    = 1'b0;
  logic [7:0] m_data   = 8'h00;
  logic [7:0] m_acc    = 8'h00;
  int         m_nbits  = 0;
  int         m_post   = 0;
  logic [7:0] hist     = 8'hFF;
  logic       sda_neg  = 1'b1;
  logic [7:0] m_crc    = 8'h00;
  logic       m_crc_ok = 1'b0;
  logic       samp, m_hs, m_lc, fin, upd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_oe = 1'b0; m_data = 8'h00;
      hist = 8'hFF; m_crc = 8'h00; m_crc_ok = 1'b0;
    end else begin
      samp = hist[S-1];
      hist = {hist[6:0], sda_neg};
      m_hs = bus.scl_hs;
      m_lc = bus.scl_lc && !bus.scl_hs;
      fin  = 1'b0;
      upd  = 1'b0;
      if (bus.abort) begin
        m_busy = 1'b0;
        m_oe   = 1'b0;
      end else if (!m_busy) begin
        if (bus.start && !m_done) begin
          m_busy = 1'b1; m_ack = bus.ack_en; m_nbits = 0; m_post = 0;
        end
      end else if (m_nbits < 8) begin
        if (m_hs) begin
          m_acc = {m_acc[6:0], samp};
          m_nbits++;
          upd = 1'b1;
        end
      end else if (m_post == 0) begin
        if (m_lc) begin m_oe = m_ack; m_post = 1; end
      end else if (m_post == 1) begin
        if (m_hs) m_post = 2;
      end else if (m_lc) begin
        m_oe = 1'b0; m_data = m_acc; m_busy = 1'b0; fin = 1'b1;
      end
`ifdef IIC_READ8_CRC_EN
      if (fin) m_crc_ok = (m_crc == 8'h00);
      if (bus.crc_clr || bus.abort) m_crc = 8'h00;
      else if (upd) m_crc = {m_crc[6:0], 1'b0} ^ ((m_crc[7] ^ samp) ? 8'h31 : 8'h00);
`endif
      m_done = fin;
    end
  end

  always @(negedge clk) begin
    sda_neg = sda;
    check("busy", 32'(bus.busy), 32'(m_busy));
    check("done", 32'(bus.done), 32'(m_done));
    check("data_out", 32'(bus.data_out), 32'(m_data));
    check("sda", 32'(sda), 32'(!(m_oe || tb_drv_low)));
`ifdef IIC_READ8_CRC_EN
    check("crc_val", 32'(bus.crc_val), 32'(m_crc));
    check("crc_ok", 32'(bus.crc_ok), 32'(m_crc_ok));
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic strobe(input logic hs, input logic lc);
    bus.scl_hs = hs;
    bus.scl_lc = lc;
    tick();
    bus.scl_hs = 1'b0;
    bus.scl_lc = 1'b0;
  endtask

  task automatic pulse_start(input logic ack);
    bus.start  = 1'b1;
    bus.ack_en = ack;
    tick();
    bus.start  = 1'b0;
  endtask

  task automatic read_byte(input logic [7:0] b, input logic ack, input int abort_after,
                           input bit start_at_done, input bit rst_in_hold,
                           input logic [7:0] prev);
    idle(1 + $urandom_range(0, 2));
    pulse_start(ack);
    for (int i = 7; i >= 0; i--) begin
      if (abort_after == 7 - i) begin
        tb_drv_low = 1'b0;
        bus.abort  = 1'b1;
        tick();
        bus.abort  = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_data", 32'(bus.data_out), 32'(prev));
        check("abort_sda", 32'(sda), 32'd1);
        return;
      end
      tb_drv_low = !b[i];
      idle(S + 1 + $urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) strobe(1'b0, 1'b1);
      if ($urandom_range(0, 4) == 0) pulse_start(!ack);
      strobe(1'b1, ($urandom_range(0, 3) == 0));
      idle($urandom_range(0, 2));
    end
    tb_drv_low = 1'b0;
    idle(1 + $urandom_range(0, 2));
    strobe(1'b0, 1'b1);
    check("ack_setup_sda", 32'(sda), 32'(!ack));
    if (rst_in_hold) begin
      #2 rst_n = 1'b0;
      #1;
      check("rst_sda", 32'(sda), 32'd1);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_data", 32'(bus.data_out), 32'd0);
      idle(2);
      rst_n = 1'b1;
      return;
    end
    idle($urandom_range(0, 2));
    if ($urandom_range(0, 1) == 0) strobe(1'b0, 1'b1);
    strobe(1'b1, 1'b0);
    check("ack_hold_sda", 32'(sda), 32'(!ack));
    idle($urandom_range(0, 2));
    strobe(1'b0, 1'b1);
    if (start_at_done) pulse_start(ack);
    else begin
      check("rd_done", 32'(bus.done), 32'd1);
      check("rd_data", 32'(bus.data_out), 32'(b));
      check("rd_busy", 32'(bus.busy), 32'd0);
      check("rd_sda", 32'(sda), 32'd1);
    end
    if (start_at_done) check("start_at_done_ignored", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0] last;
    logic [7:0] rb;
    logic       ra;
    bus.start  = 1'b0;
    bus.ack_en = 1'b0;
    bus.abort  = 1'b0;
    bus.scl_hs = 1'b0;
    bus.scl_lc = 1'b0;
`ifdef IIC_READ8_CRC_EN
    bus.crc_clr = 1'b0;
`endif
    idle(3);
    rst_n = 1'b1;
    idle(2);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_data", 32'(bus.data_out), 32'd0);
    check("reset_sda", 32'(sda), 32'd1);

    read_byte(8'hA5, 1'b1, -1, 1'b0, 1'b0, 8'h00);
    read_byte(8'hFF, 1'b1, 4, 1'b0, 1'b0, 8'hA5);
    read_byte(8'h81, 1'b1, -1, 1'b0, 1'b0, 8'hA5);
    read_byte(8'h3C, 1'b0, -1, 1'b0, 1'b0, 8'h81);
    check("lit_3c", 32'(bus.data_out), 32'h3C);

    last = 8'h3C;
    for (int n = 0; n < 24; n++) begin
      rb = 8'($urandom_range(0, 255));
      ra = 1'($urandom_range(0, 1));
      read_byte(rb, ra, -1, ($urandom_range(0, 3) == 0), 1'b0, last);
      last = rb;
    end
    idle(2);
    check("rand_last", 32'(bus.data_out), 32'(last));

`ifdef IIC_READ8_CRC_EN
    bus.crc_clr = 1'b1;
    tick();
    bus.crc_clr = 1'b0;
    read_byte(8'h68, 1'b1, -1, 1'b0, 1'b0, last);
    read_byte(8'h3A, 1'b1, -1, 1'b0, 1'b0, 8'h68);
    check("crc_val_683a", 32'(bus.crc_val), 32'h7C);
    read_byte(8'h7C, 1'b0, -1, 1'b0, 1'b0, 8'h3A);
    tick();
    check("crc_ok_good", 32'(bus.crc_ok), 32'd1);
    bus.crc_clr = 1'b1;
    tick();
    bus.crc_clr = 1'b0;
    read_byte(8'h68, 1'b1, -1, 1'b0, 1'b0, 8'h7C);
    read_byte(8'h3A, 1'b1, -1, 1'b0, 1'b0, 8'h68);
    read_byte(8'h7D, 1'b0, -1, 1'b0, 1'b0, 8'h3A);
    tick();
    check("crc_ok_bad", 32'(bus.crc_ok), 32'd0);
`endif

    read_byte(8'h5A, 1'b1, -1, 1'b0, 1'b1, 8'h00);
    idle(2);
    check("post_rst_data", 32'(bus.data_out), 32'd0);
    read_byte(8'hC3, 1'b0, -1, 1'b0, 1'b0, 8'h00);
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
